// File: rtl/ad7606_emu_if.sv
// Parallel AD7606 bus between the controller (master) and the ADC responder (slave).
interface ad7606_emu_if;
    logic        ad_convstab;
    logic        ad_cs;
    logic        ad_rd;
    logic        ad_reset;
    logic [2:0]  ad_os;
    logic [15:0] ad_data;
    logic        ad_busy;
    logic        first_data;
    logic [1:0]  state_out;

    modport master (
        output ad_convstab, ad_cs, ad_rd, ad_reset, ad_os,
        input  ad_data, ad_busy, first_data, state_out
    );

    modport slave (
        input  ad_convstab, ad_cs, ad_rd, ad_reset, ad_os,
        output ad_data, ad_busy, first_data, state_out
    );
endinterface

// File: rtl/ad7606_emu.sv
// AD7606 responder: BUSY timing, 8-channel deterministic snapshot, CS/RD readout.
// Optional AD_EMU_LFSR_EN scrambles the low byte of each sample with a 16-bit LFSR.
module ad7606_emu #(
    parameter int unsigned CONV_CYCLES = 200,
    parameter logic [12:0] CNT_INIT    = 13'd0
) (
    input  logic         clk,
    input  logic         rst,
    ad7606_emu_if.slave  bus
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned NCH    = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned OS_W   = 3;
    localparam int unsigned BUSY_W = $clog2(CONV_CYCLES * 64 + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic              busy_q,     busy_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              first_q,    first_d;
    logic [PTR_W-1:0]  ptr_q,      ptr_d;
    logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [DATA_W-1:0] snap_q [NCH];
    logic [DATA_W-1:0] snap_d [NCH];
    logic              convst_q;
    logic              rd_q;

    logic              convst_rise;
    logic              rd_fall;
    logic [OS_W-1:0]   os_eff;
    logic [BUSY_W-1:0] conv_len_m1;

`ifdef AD_EMU_LFSR_EN
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic              lfsr_fb;
`endif

    // Edge detection against a one-cycle registered copy of the raw inputs
    always_ff @(posedge clk) begin
        convst_q <= bus.ad_convstab;
        rd_q     <= bus.ad_rd;
    end

    assign convst_rise = bus.ad_convstab & ~convst_q;
    assign rd_fall     = ~bus.ad_rd & rd_q & ~bus.ad_cs;
    assign os_eff      = (bus.ad_os == 3'd7) ? OS_W'(0) : bus.ad_os;
    assign conv_len_m1 = BUSY_W'(BUSY_W'(CONV_CYCLES) << os_eff) - BUSY_W'(1);

`ifdef AD_EMU_LFSR_EN
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

    // Next-state and output logic; a read sampled on the completion edge uses
    // the old snapshot, then the snapshot load and pointer clear take over.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        data_d     = data_q;
        first_d    = first_q;
        ptr_d      = ptr_q;
        conv_cnt_d = conv_cnt_q;
        busy_cnt_d = busy_cnt_q;
        snap_d     = snap_q;
`ifdef AD_EMU_LFSR_EN
        lfsr_d     = lfsr_q;
`endif

        if (rd_fall) begin
            data_d  = snap_q[ptr_q];
            first_d = (ptr_q == PTR_W'(0));
            ptr_d   = PTR_W'(ptr_q + PTR_W'(1));
        end

        case (state_q)
            S_IDLE, S_READY: begin
                if (convst_rise) begin
                    state_d    = S_CONV;
                    busy_d     = 1'b1;
                    busy_cnt_d = conv_len_m1;
                end
            end
            S_CONV: begin
                if (busy_cnt_q == BUSY_W'(0)) begin
                    for (int ch = 0; ch < NCH; ch++) begin
                        snap_d[ch] = {PTR_W'(ch), conv_cnt_q};
`ifdef AD_EMU_LFSR_EN
                        snap_d[ch][7:0] = snap_d[ch][7:0] ^ lfsr_q[7:0] ^ {5'b0, PTR_W'(ch)};
`endif
                    end
`ifdef AD_EMU_LFSR_EN
                    lfsr_d     = {lfsr_q[14:0], lfsr_fb};
`endif
                    state_d    = S_READY;
                    busy_d     = 1'b0;
                    conv_cnt_d = CNT_W'(conv_cnt_q + CNT_W'(1));
                    ptr_d      = PTR_W'(0);
                end else begin
                    busy_cnt_d = BUSY_W'(busy_cnt_q - BUSY_W'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; both resets are synchronous and clear everything
    always_ff @(posedge clk) begin
        if (rst || bus.ad_reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            data_q     <= '0;
            first_q    <= 1'b0;
            ptr_q      <= '0;
            conv_cnt_q <= CNT_INIT;
            busy_cnt_q <= '0;
            for (int i = 0; i < NCH; i++) snap_q[i] <= '0;
`ifdef AD_EMU_LFSR_EN
            lfsr_q     <= 16'hACE1;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            first_q    <= first_d;
            ptr_q      <= ptr_d;
            conv_cnt_q <= conv_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            snap_q     <= snap_d;
`ifdef AD_EMU_LFSR_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    assign bus.ad_busy    = busy_q;
    assign bus.ad_data    = data_q;
    assign bus.first_data = first_q;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_ad7606_emu.sv
// Randomized bench for ad7606_emu against a sample-level reference model.
module tb_ad7606_emu;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    ad7606_emu_if bus();

    ad7606_emu #(.CONV_CYCLES(200), .CNT_INIT(13'd0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: conversion count, snapshot table, read pointer, last read
    int          m_cnt;
    logic [15:0] m_snap [8];
    int          m_ptr;
    logic [15:0] m_data;
    logic        m_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) m_snap[i] = 16'h0000;
        m_ptr   = 0;
        m_data  = 16'h0000;
        m_first = 1'b0;
    endtask

    task automatic model_complete();
        for (int ch = 0; ch < 8; ch++) m_snap[ch] = 16'(ch * 8192 + m_cnt);
        m_cnt = (m_cnt + 1) % 8192;
        m_ptr = 0;
    endtask

    task automatic model_read();
        m_data  = m_snap[m_ptr];
        m_first = (m_ptr == 0);
        m_ptr   = (m_ptr + 1) % 8;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},  32'(bus.ad_busy),    32'd0);
        check({tag, "_data"},  32'(bus.ad_data),    32'd0);
        check({tag, "_first"}, 32'(bus.first_data), 32'd0);
        check({tag, "_state"}, 32'(bus.state_out),  32'd0);
    endtask

    task automatic do_reset(input bit use_pin);
        if (use_pin) bus.ad_reset = 1'b1; else rst = 1'b1;
        tick();
        bus.ad_reset = 1'b0;
        rst          = 1'b0;
        model_reset();
        check_cleared(use_pin ? "pinrst" : "rst");
    endtask

    // One CS/RD strobe; with cs_hi the edge must be ignored
    task automatic rd_once(input bit cs_hi);
        bus.ad_cs = cs_hi;
        bus.ad_rd = 1'b0;
        tick();
        if (!cs_hi) model_read();
        check(cs_hi ? "rd_cs_hi_data" : "rd_data", 32'(bus.ad_data), 32'(m_data));
        check(cs_hi ? "rd_cs_hi_first" : "rd_first", 32'(bus.first_data), 32'(m_first));
        bus.ad_rd = 1'b1;
        tick();
        bus.ad_cs = 1'b1;
    endtask

    // Conversion with optional extra convst edge, ad_reset and read at given busy cycles
    task automatic convert(input int os, input int dbl_at, input int rst_at, input int rd_at);
        int n;
        int seen;
        bit pend;
        bit aborted;
        n       = 200 << ((os == 7) ? 0 : os);
        seen    = 0;
        pend    = 1'b0;
        aborted = 1'b0;
        bus.ad_os       = 3'(os);
        bus.ad_convstab = 1'b1;
        tick();
        bus.ad_convstab = 1'b0;
        while (1) begin
            if (pend) begin
                model_read();
                check("rd_conv_data",  32'(bus.ad_data),    32'(m_data));
                check("rd_conv_first", 32'(bus.first_data), 32'(m_first));
                bus.ad_rd = 1'b1;
                bus.ad_cs = 1'b1;
                pend      = 1'b0;
            end
            if (bus.ad_busy !== 1'b1) break;
            seen++;
            if (seen == 1) check("state_conv", 32'(bus.state_out), 32'd1);
            if (seen > 20000) begin
                check("busy_timeout", 32'(seen), 32'(n));
                aborted = 1'b1;
                break;
            end
            bus.ad_convstab = (seen == dbl_at);
            bus.ad_reset    = (seen == rst_at);
            if (seen == rd_at) begin
                bus.ad_cs = 1'b0;
                bus.ad_rd = 1'b0;
                pend      = 1'b1;
            end
            tick();
            if (seen == rst_at) begin
                bus.ad_reset = 1'b0;
                model_reset();
                check_cleared("conv_rst");
                aborted = 1'b1;
                break;
            end
        end
        bus.ad_convstab = 1'b0;
        if (!aborted) begin
            check("busy_len", 32'(seen), 32'(n));
            model_complete();
            check("state_ready", 32'(bus.state_out), 32'd2);
        end
        tick();
    endtask

    initial begin
        int os_pick;
        int n;
        rst             = 1'b1;
        bus.ad_convstab = 1'b0;
        bus.ad_cs       = 1'b1;
        bus.ad_rd       = 1'b1;
        bus.ad_reset    = 1'b0;
        bus.ad_os       = 3'd0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        check_cleared("init");

        // Reads before any conversion return zero
        rd_once(1'b0);

        // Basic conversion and a full channel sweep
        do_reset(1'b0);
        convert(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) rd_once(1'b0);

        // Oversampling lengths, including reserved os=7
        convert(3, 0, 0, 0);
        convert(7, 0, 0, 0);

        // Extra convst edge mid-conversion is ignored
        do_reset(1'b0);
        convert(0, 50, 0, 0);
        convert(0, 0, 0, 0);
        rd_once(1'b0);

        // Two conversions then six reads
        do_reset(1'b1);
        convert(0, 0, 0, 0);
        convert(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) rd_once(1'b0);

        // ad_reset mid-conversion
        convert(0, 0, 100, 0);
        convert(0, 0, 0, 0);
        rd_once(1'b0);

        // Nine reads wrap, then an ignored read with CS high
        convert(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) rd_once(1'b0);
        rd_once(1'b1);

        // Read during conversion, and read colliding with the snapshot load
        rd_once(1'b0);
        convert(0, 0, 0, 30);
        convert(0, 0, 0, 200);
        for (int i = 0; i < 3; i++) rd_once(1'b0);

        // Randomized mix
        for (int it = 0; it < 24; it++) begin
            os_pick = $urandom_range(0, 4);
            if (os_pick == 3) os_pick = 7;
            if (os_pick == 4) os_pick = $urandom_range(0, 7);
            if (os_pick > 2 && os_pick < 7) os_pick = 2;
            n = 200 << ((os_pick == 7) ? 0 : os_pick);
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(0, 1) == 1);
            convert(os_pick,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0,
                    ($urandom_range(0, 7) == 0) ? $urandom_range(2, n - 1) * 2 - 1 : 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, n / 2) * 2 : 0);
            for (int r = $urandom_range(0, 10); r > 0; r--) rd_once($urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
